// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with press/release debounce.
//
// Drives one keypad column at a time, synchronizes the asynchronous row lines and, once a key
// has been stable for DEBOUNCE_CYCLES, emits a single-cycle write strobe with the one-hot column
// and row of that key. The scan stays frozen on the captured column until the key has been
// released for DEBOUNCE_CYCLES, so each physical press yields exactly one strobe.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   rows       raw keypad row lines, active-high, asynchronous
//   col_drive  one-hot active-high column drive
//   WE_send    single-cycle strobe: new key captured
//   cols       one-hot column of the last captured key (0 until the first strobe)
//   synchrows  one-hot row of the last captured key (0 until the first strobe)
module keypad_scan #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] col_drive,
  output logic       WE_send,
  output logic [3:0] cols,
  output logic [3:0] synchrows
);

  localparam int unsigned DwellW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DwellW-1:0] DwellMax = DwellW'(SCAN_DIV - 1);
  localparam logic [DbW-1:0]    DbMax    = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StScan, StDbPress, StHeld, StDbRelease} state_e;

  state_e            state_q, state_d;
  logic [3:0]        row_meta_q, rs_q;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [DbW-1:0]    db_q, db_d;
  logic [3:0]        col_q, col_d;
  logic [3:0]        cap_row_q, cap_row_d;
  logic [3:0]        cols_q, cols_d;
  logic [3:0]        srows_q, srows_d;
  logic              we_q, we_d;

  logic       lk;
  logic [3:0] col_next;
  logic [3:0] rs_lowest;

  // Level of the row that was captured; the column is frozen so this tracks one key.
  assign lk        = |(rs_q & cap_row_q);
  assign col_next  = {col_q[2:0], col_q[3]};
  // Isolate the lowest set bit: lowest-index row wins when several are active.
  assign rs_lowest = rs_q & (~rs_q + 4'd1);

  // State register and datapath flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StScan;
      row_meta_q <= '0;
      rs_q       <= '0;
      dwell_q    <= '0;
      db_q       <= '0;
      col_q      <= 4'b0001;
      cap_row_q  <= '0;
      cols_q     <= '0;
      srows_q    <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_meta_q <= rows;
      rs_q       <= row_meta_q;
      dwell_q    <= dwell_d;
      db_q       <= db_d;
      col_q      <= col_d;
      cap_row_q  <= cap_row_d;
      cols_q     <= cols_d;
      srows_q    <= srows_d;
      we_q       <= we_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    db_d      = db_q;
    col_d     = col_q;
    cap_row_d = cap_row_q;
    cols_d    = cols_q;
    srows_d   = srows_q;
    we_d      = 1'b0;
    unique case (state_q)
      StScan: begin
        if (dwell_q == DwellMax) begin
          dwell_d = '0;
          if (rs_q == 4'b0000) begin
            col_d = col_next;
          end else begin
            cap_row_d = rs_lowest;
            db_d      = '0;
            state_d   = StDbPress;
          end
        end else begin
          dwell_d = dwell_q + DwellW'(1);
        end
      end
      StDbPress: begin
        if (!lk) begin
          dwell_d = '0;
          state_d = StScan;
        end else if (db_q == DbMax) begin
          we_d    = 1'b1;
          cols_d  = col_q;
          srows_d = cap_row_q;
          state_d = StHeld;
        end else begin
          db_d = db_q + DbW'(1);
        end
      end
      StHeld: begin
        if (!lk) begin
          db_d    = '0;
          state_d = StDbRelease;
        end
      end
      StDbRelease: begin
        if (lk) begin
          state_d = StHeld;
        end else if (db_q == DbMax) begin
          col_d   = col_next;
          dwell_d = '0;
          state_d = StScan;
        end else begin
          db_d = db_q + DbW'(1);
        end
      end
      default: state_d = StScan;
    endcase
  end

  // Outputs come straight from flops.
  always_comb begin
    col_drive = col_q;
    WE_send   = we_q;
    cols      = cols_q;
    synchrows = srows_q;
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CYCLES=8. A keypad matrix
// (key_mask per column) produces rows from the DUT column drive; a reference model predicts
// the scan column and every strobe, which a separate monitor checks against WE_send.
module tb_keypad_scan;

  localparam int ScanDiv   = 4;
  localparam int DebCycles = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows = 4'b0000;
  logic [3:0] col_drive;
  logic       WE_send;
  logic [3:0] cols;
  logic [3:0] synchrows;

  keypad_scan #(
    .SCAN_DIV       (ScanDiv),
    .DEBOUNCE_CYCLES(DebCycles)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .col_drive(col_drive),
    .WE_send  (WE_send),
    .cols     (cols),
    .synchrows(synchrows)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] col;
    logic [3:0] row;
  } exp_t;
  exp_t sb[$];

  logic [3:0] key_mask[4];

  // Reference model: keypad behaviour described as column index, tracked row index and
  // run lengths of a stable level.
  int         m_col, m_dwell, m_track, m_run;
  bit         m_acc, m_rel;
  logic [3:0] m_s1, m_s2, m_cols, m_rows;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_dwell = 0; m_track = -1; m_run = 0;
    m_acc = 0; m_rel = 0;
    m_s1 = '0; m_s2 = '0; m_cols = '0; m_rows = '0;
  endtask

  // Predicts the effect of the next rising edge given the rows the DUT will sample there.
  task automatic model_step(input logic [3:0] r);
    logic [3:0] rs;
    exp_t       e;
    rs   = m_s2;
    m_s2 = m_s1;
    m_s1 = r;
    if (m_track < 0) begin
      if (m_dwell == ScanDiv - 1) begin
        m_dwell = 0;
        if (rs == 4'b0000) begin
          m_col = (m_col + 1) % 4;
        end else begin
          for (int i = 3; i >= 0; i--) if (rs[i]) m_track = i;
          m_run = 0; m_acc = 0; m_rel = 0;
        end
      end else begin
        m_dwell++;
      end
    end else if (!m_acc) begin
      if (!rs[m_track]) begin
        m_track = -1;
      end else if (m_run == DebCycles - 1) begin
        m_acc  = 1;
        m_cols = 4'(1 << m_col);
        m_rows = 4'(1 << m_track);
        e.cyc  = cyc + 1;
        e.col  = m_cols;
        e.row  = m_rows;
        sb.push_back(e);
      end else begin
        m_run++;
      end
    end else if (!m_rel) begin
      if (!rs[m_track]) begin
        m_rel = 1;
        m_run = 0;
      end
    end else begin
      if (rs[m_track]) begin
        m_rel = 0;
      end else if (m_run == DebCycles - 1) begin
        m_track = -1;
        m_col   = (m_col + 1) % 4;
        m_dwell = 0;
      end else begin
        m_run++;
      end
    end
  endtask

  // One clock: check state after the last edge, then present rows for the next edge.
  task automatic tick();
    logic [3:0] r;
    @(negedge clk);
    check("col_drive", col_drive, 4'(1 << m_col));
    check("cols", cols, m_cols);
    check("synchrows", synchrows, m_rows);
    r = '0;
    for (int i = 0; i < 4; i++) if (col_drive == 4'(1 << i)) r = key_mask[i];
    rows = r;
    if (reset) model_step(r);
    else model_reset();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_keys();
    for (int i = 0; i < 4; i++) key_mask[i] = '0;
  endtask

  // Strobe monitor.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_strobe: WE_send 0 at cycle %0d, expected 1", sb[0].cyc);
      void'(sb.pop_front());
    end
    if (WE_send === 1'b1) begin
      strobe_cnt++;
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: WE_send 1 at cycle %0d, expected 0", cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_cols", cols, e.col);
        check("strobe_synchrows", synchrows, e.row);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int c;
    int i;
    clear_keys();
    model_reset();

    // Reset asserted before any clock edge.
    #1 reset = 1'b0;
    #1;
    check("reset_col_drive", col_drive, 4'b0001);
    check("reset_we", {3'b000, WE_send}, 4'b0000);
    check("reset_cols", cols, 4'b0000);
    check("reset_synchrows", synchrows, 4'b0000);
    ticks(3);
    @(posedge clk);
    #1 reset = 1'b1;

    // Idle scan.
    ticks(40);
    check_int("idle_strobes", strobe_cnt, 0);

    // Clean press of column 1, row 2.
    key_mask[1] = 4'b0100;
    ticks(40);
    check_int("press_strobes", strobe_cnt, 1);
    check("press_cols", cols, 4'b0010);
    check("press_synchrows", synchrows, 4'b0100);
    check("held_col_drive", col_drive, 4'b0010);
    clear_keys();
    ticks(25);

    // Bouncing press, then stable, then bouncing release.
    base = strobe_cnt;
    for (i = 0; i < 20; i++) begin
      key_mask[1] = ((i / 3) % 2 == 0) ? 4'b0100 : 4'b0000;
      tick();
    end
    check_int("bounce_no_strobe", strobe_cnt - base, 0);
    key_mask[1] = 4'b0100;
    ticks(40);
    check_int("bounce_one_strobe", strobe_cnt - base, 1);
    for (i = 0; i < 5; i++) begin
      key_mask[1] = (i % 2 == 1) ? 4'b0100 : 4'b0000;
      tick();
    end
    key_mask[1] = 4'b0000;
    ticks(25);
    check_int("release_no_strobe", strobe_cnt - base, 1);

    // Two rows at capture, then a second key while held.
    base = strobe_cnt;
    c = $urandom_range(0, 3);
    key_mask[c] = 4'b1010;
    ticks(40);
    check_int("multi_strobe", strobe_cnt - base, 1);
    check("multi_synchrows", synchrows, 4'b0010);
    check("multi_cols", cols, 4'(1 << c));
    key_mask[(c + 2) % 4] = 4'b0001;
    ticks(30);
    check_int("second_key_ignored", strobe_cnt - base, 1);
    clear_keys();
    ticks(30);

    // Random presses with random bounce.
    for (int n = 0; n < 10; n++) begin
      int hold;
      for (int k = 0; k < 4; k++)
        key_mask[k] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      hold = $urandom_range(5, 50);
      for (int t = 0; t < hold; t++) begin
        if (t < 8 && $urandom_range(0, 1) == 1) begin
          for (int k = 0; k < 4; k++) key_mask[k] = key_mask[k] ^ 4'($urandom);
        end
        tick();
      end
      clear_keys();
      ticks($urandom_range(5, 30));
    end
    ticks(30);

    // Asynchronous reset in the middle of a press debounce.
    key_mask[2] = 4'b1000;
    i = 0;
    while (i < 200 && !(m_track >= 0 && !m_acc && m_run == 6)) begin
      tick();
      i++;
    end
    check_int("reach_db6", (i < 200) ? 1 : 0, 1);
    base = strobe_cnt;
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("async_col_drive", col_drive, 4'b0001);
    check("async_cols", cols, 4'b0000);
    check("async_synchrows", synchrows, 4'b0000);
    check("async_we", {3'b000, WE_send}, 4'b0000);
    clear_keys();
    ticks(3);
    @(posedge clk);
    #1 reset = 1'b1;
    ticks(30);
    check_int("async_no_strobe", strobe_cnt - base, 0);
    check_int("pending_strobes", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
